// File: rtl/pre_quant_unpacker.sv
// pre_quant_unpacker: streaming dequantizer feeding the PE array.
// Takes 32-bit words holding four uint8 activations (zero point 128), turns
// each byte back into a signed value and scales it by a left shift. Emits one
// DATA_BITS-wide element per cycle under valid/ready flow control, and counts
// elements against a per-tile length.
// Ports:
//   clk, rst              clock, async active-high reset
//   start, len, shift_amt tile start pulse, element count, shift scale
//   in_valid/in_ready/in_data     packed input word stream (lane 0 first)
//   out_valid/out_ready/out_data  dequantized element stream
//   out_last              final element of the tile
//   busy, done            tile in progress, one-cycle completion pulse
module pre_quant_unpacker #(
   parameter int unsigned DATA_BITS = 32,
   parameter int unsigned LEN_BITS  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [LEN_BITS-1:0]  len,
   input  logic [2:0]           shift_amt,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_BITS-1:0] out_data,
   output logic                 out_last,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e              state_q, state_d;
   logic [31:0]         word_q, word_d;
   logic                word_vld_q, word_vld_d;
   logic [1:0]          lane_q, lane_d;
   logic [LEN_BITS-1:0] remaining_q, remaining_d;
   logic [2:0]          shift_q, shift_d;

   logic                 last_elem;
   logic                 word_finish;
   logic                 out_hs;
   logic                 in_hs;
   logic [7:0]           cur_byte;
   logic [7:0]           sbyte;
   logic [DATA_BITS-1:0] sext;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         word_q      <= '0;
         word_vld_q  <= 1'b0;
         lane_q      <= 2'd0;
         remaining_q <= '0;
         shift_q     <= 3'd0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         word_vld_q  <= word_vld_d;
         lane_q      <= lane_d;
         remaining_q <= remaining_d;
         shift_q     <= shift_d;
      end
   end

   // Byte select, zero-point removal (XOR 0x80), sign extension and scale.
   always_comb begin
      cur_byte = word_q[7:0];
      unique case (lane_q)
         2'd0: cur_byte = word_q[7:0];
         2'd1: cur_byte = word_q[15:8];
         2'd2: cur_byte = word_q[23:16];
         2'd3: cur_byte = word_q[31:24];
         default: cur_byte = word_q[7:0];
      endcase
      sbyte = cur_byte ^ 8'h80;
      sext  = {{(DATA_BITS-8){sbyte[7]}}, sbyte};
   end

   always_comb begin
      last_elem   = (remaining_q == LEN_BITS'(1));
      word_finish = (lane_q == 2'd3) || last_elem;
      out_valid   = word_vld_q;
      out_last    = word_vld_q && last_elem;
      out_data    = word_vld_q ? (sext << shift_q) : '0;
      busy        = (state_q == StRun) || (state_q == StDone);
      done        = (state_q == StDone);
      // Fetch only while the held word cannot cover the remaining elements, and
      // only when the slot is empty or is being vacated this very cycle.
      in_ready    = (state_q == StRun)
                    && (remaining_q > {{(LEN_BITS-1){1'b0}}, word_vld_q})
                    && (!word_vld_q || (out_ready && word_finish));
      out_hs      = out_valid && out_ready;
      in_hs       = in_valid && in_ready;
   end

   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      word_vld_d  = word_vld_q;
      lane_d      = lane_q;
      remaining_d = remaining_q;
      shift_d     = shift_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               remaining_d = len;
               shift_d     = shift_amt;
               state_d     = (len != '0) ? StRun : StDone;
            end
         end
         StRun: begin
            if (out_hs) begin
               remaining_d = remaining_q - LEN_BITS'(1);
               if (word_finish) begin
                  lane_d     = 2'd0;
                  word_vld_d = 1'b0;
               end else begin
                  lane_d = lane_q + 2'd1;
               end
               if (last_elem) state_d = StDone;
            end
            if (in_hs) begin
               word_d     = in_data;
               word_vld_d = 1'b1;
               lane_d     = 2'd0;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_pre_quant_unpacker.sv
// Self-checking bench for pre_quant_unpacker: a reference model derives every
// element from the packed words, a negedge monitor compares the DUT each
// cycle, and directed tiles cover stalls, partial words, len=0 and reset.
module tb_pre_quant_unpacker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] len = '0;
   logic [2:0]  shift_amt = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        out_last;
   logic        busy;
   logic        done;

   pre_quant_unpacker #(.DATA_BITS(32), .LEN_BITS(16)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .shift_amt(shift_amt),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   logic [31:0] tile_words [4];
   longint      exp_q[$];
   longint      obs_q[$];
   int          in_hs_cnt, done_cnt, done_cyc, first_vld, cyc;
   logic        pv = 1'b0, pr = 1'b0, pdone = 1'b0;
   logic [31:0] pd = '0;

   task automatic check(input bit ok, input string name, input longint act, input longint exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Element idx of the tile: unpack byte, remove zero point, scale.
   function automatic longint model_elem(int idx, int sh);
      int b;
      b = int'((tile_words[idx / 4] >> (8 * (idx % 4))) & 32'hFF);
      return longint'(b - 128) * (longint'(1) << sh);
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (out_valid) begin
            if (first_vld < 0) first_vld = cyc;
            check(exp_q.size() != 0, "unexpected_out", longint'($signed(out_data)), 0);
            if (exp_q.size() != 0) begin
               check(longint'($signed(out_data)) == exp_q[0], "out_data",
                     longint'($signed(out_data)), exp_q[0]);
               check(out_last == (exp_q.size() == 1), "out_last", out_last, exp_q.size() == 1);
               if (out_ready) begin
                  obs_q.push_back(longint'($signed(out_data)));
                  void'(exp_q.pop_front());
               end
            end
            if (!out_ready) check(!in_ready, "in_ready_stall", in_ready, 0);
         end else begin
            check(out_data == 0 && !out_last, "idle_outputs", out_data, 0);
         end
         if (pv && !pr)
            check(out_valid && out_data == pd, "stall_hold", out_data, pd);
         if (in_valid && in_ready) in_hs_cnt++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (pdone) check(!busy && !done, "busy_after_done", busy, 0);
         pv = out_valid; pr = out_ready; pd = out_data; pdone = done;
      end else begin
         pv = 1'b0; pdone = 1'b0;
      end
   end

   task automatic run_tile(input int tlen, input int tsh, input int nw, input logic [7:0] pat,
                           input int plen, input int abort_after, input int spam,
                           input bit chk_tput);
      int  k, widx;
      bit  hs, fin;
      exp_q.delete(); obs_q.delete();
      in_hs_cnt = 0; done_cnt = 0; first_vld = -1; done_cyc = 0;
      for (int i = 0; i < tlen; i++) exp_q.push_back(model_elem(i, tsh));
      widx = 0; fin = 0; k = 0;
      in_valid  = (nw > 0);
      in_data   = tile_words[0];
      out_ready = pat[0];
      start = 1'b1; len = 16'(tlen); shift_amt = 3'(tsh);
      @(posedge clk); #1;
      start = (spam == 0);
      if (spam == 0) len = 16'd7;
      check(busy == 1'b1, "busy_after_start", busy, 1);
      check(in_ready == (tlen != 0), "in_ready_after_start", in_ready, tlen != 0);
      while (k < 200 && !fin) begin
         @(negedge clk);
         hs  = in_valid && in_ready;
         fin = done;
         @(posedge clk); #1;
         k++;
         if (hs) widx++;
         in_valid  = (widx < nw);
         in_data   = tile_words[(widx < 4) ? widx : 0];
         out_ready = pat[k % plen];
         start     = (k == spam);
         if (k == spam) len = 16'd7;
         if (abort_after > 0 && obs_q.size() >= abort_after) begin
            rst = 1'b1; in_valid = 1'b0; start = 1'b0;
            #1;
            check({in_ready, out_valid, out_last, busy, done} == 5'b0, "reset_ctrl_outs",
                  {in_ready, out_valid, out_last, busy, done}, 0);
            check(out_data == 0, "reset_out_data", out_data, 0);
            exp_q.delete();
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            check(done_cnt == 0, "no_done_after_abort", done_cnt, 0);
            return;
         end
      end
      check(fin, "tile_timeout", k, 0);
      @(posedge clk); #1;
      check(exp_q.size() == 0, "all_elements", exp_q.size(), 0);
      check(in_hs_cnt == (tlen + 3) / 4, "in_handshakes", in_hs_cnt, (tlen + 3) / 4);
      check(done_cnt == 1, "done_pulses", done_cnt, 1);
      if (tlen == 0) check(k == 1, "len0_done_latency", k, 1);
      if (chk_tput) check(done_cyc - first_vld == tlen, "throughput", done_cyc - first_vld, tlen);
   endtask

   task automatic check_lits(input longint lit[], input int sh, input string name);
      for (int i = 0; i < lit.size(); i++) begin
         check(model_elem(i, sh) == lit[i], {name, "_model"}, model_elem(i, sh), lit[i]);
      end
   endtask

   task automatic check_obs(input longint lit[], input string name);
      check(obs_q.size() == lit.size(), {name, "_count"}, obs_q.size(), lit.size());
      for (int i = 0; i < lit.size() && i < obs_q.size(); i++)
         check(obs_q[i] == lit[i], {name, "_dut"}, obs_q[i], lit[i]);
   endtask

   initial begin
      longint lit1[] = '{-1, -128, 127, 0};
      longint lit2[] = '{-4, -512, 508, 0};
      longint lit3[] = '{0, 1, 2, 3, 4, 5};
      longint lit4[] = '{32, -64, 64};
      cyc = 0;
      #12;
      check({in_ready, out_valid, out_last, busy, done} == 5'b0, "por_ctrl_outs",
            {in_ready, out_valid, out_last, busy, done}, 0);
      check(out_data == 0, "por_out_data", out_data, 0);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;

      tile_words = '{32'h80FF007F, 32'h0, 32'h0, 32'h0};
      check_lits(lit1, 0, "t1");
      run_tile(4, 0, 1, 8'hFF, 1, 0, -1, 1);
      check_obs(lit1, "t1");

      check_lits(lit2, 2, "t2");
      run_tile(4, 2, 1, 8'hFF, 1, 0, -1, 1);
      check_obs(lit2, "t2");

      tile_words = '{32'h83828180, 32'hFFFF8584, 32'h0, 32'h0};
      check_lits(lit3, 0, "t3");
      run_tile(6, 0, 2, 8'hFF, 1, 0, -1, 1);
      check_obs(lit3, "t3");

      // Stalls with out_ready cycling 1,0,0 and an ignored start mid-tile.
      tile_words = '{32'h00C040A0, 32'h0, 32'h0, 32'h0};
      check_lits(lit4, 0, "t4");
      run_tile(3, 0, 1, 8'b0000_0001, 3, 0, 3, 0);
      check_obs(lit4, "t4");

      // len=0 with a start held into the DONE cycle.
      run_tile(0, 0, 1, 8'hFF, 1, 0, 0, 0);
      check(in_hs_cnt == 0, "len0_no_input", in_hs_cnt, 0);

      // Reset after two of eight elements, then a clean tile.
      tile_words = '{32'h04030201, 32'h08070605, 32'h0, 32'h0};
      run_tile(8, 1, 2, 8'hFF, 1, 2, -1, 0);
      tile_words = '{32'h80FF007F, 32'h0, 32'h0, 32'h0};
      run_tile(4, 0, 1, 8'hFF, 1, 0, -1, 1);
      check_obs(lit1, "t6");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
